// File: rtl/rvfpm_mem_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvfpm_mem_sched_pkg
// Brief   : Shared types for the FPU CORE-V-XIF memory scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package rvfpm_mem_sched_pkg;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_MEM_WIDTH = 32;
  localparam int FLEN        = 32;

  localparam logic [2:0] MEM_SIZE_BYTE = 3'd0;
  localparam logic [2:0] MEM_SIZE_HALF = 3'd1;
  localparam logic [2:0] MEM_SIZE_WORD = 3'd2;

  typedef logic [1:0] mem_sched_state_t;
  localparam mem_sched_state_t ST_IDLE   = 2'd0;
  localparam mem_sched_state_t ST_REQ    = 2'd1;
  localparam mem_sched_state_t ST_RESULT = 2'd2;
  localparam mem_sched_state_t ST_RETIRE = 2'd3;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]    id;
    logic [31:0]              addr;
    logic [1:0]               mode;
    logic                     we;
    logic [2:0]               size;
    logic [X_MEM_WIDTH/8-1:0] be;
    logic [1:0]               attr;
    logic [X_MEM_WIDTH-1:0]   wdata;
    logic                     last;
    logic                     spec;
  } x_mem_req_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic                   we;
    logic [31:0]            addr;
    logic [2:0]             size;
    logic [4:0]             rd;
    logic [X_MEM_WIDTH-1:0] wdata;
    logic [1:0]             mode;
    logic                   committed;
    logic                   killed;
  } mem_q_entry_t;

  function automatic logic mem_misaligned(input logic [2:0] size, input logic [1:0] a);
    return (size > MEM_SIZE_WORD) ||
           ((size == MEM_SIZE_HALF) && a[0]) ||
           ((size == MEM_SIZE_WORD) && (a != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvfpm_mem_sched_queue.sv
`default_nettype none
// ============================================================================
// Module  : rvfpm_mem_queue
// Brief   : In-order circular FIFO of pending FP loads/stores with id-matched
//           commit/kill flag update; exposes the head entry.
// Revision: 1.0 - initial release
// ============================================================================
module rvfpm_mem_queue
  import rvfpm_mem_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  mem_q_entry_t          push_entry,
  input  logic                  pop,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output mem_q_entry_t          head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  mem_q_entry_t   r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  mem_q_entry_t   w_new;
  logic           w_new_hit;

  // A commit/kill for the id being enqueued this cycle lands on the new entry.
  always_comb begin
    w_new           = push_entry;
    w_new_hit       = commit_valid && (commit_id == push_entry.id);
    w_new.committed = w_new_hit && !commit_kill;
    w_new.killed    = w_new_hit && commit_kill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid && r_valid[i] && (r_mem[i].id == commit_id)) begin
          if (commit_kill) r_mem[i].killed    <= 1'b1;
          else             r_mem[i].committed <= 1'b1;
        end
      end
      if (pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      // Push is ordered after pop so a full-queue swap keeps the slot valid.
      if (push) begin
        r_mem[r_wr_ptr]   <= w_new;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == DEPTH[AW:0]);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rvfpm_mem_sched.sv
`default_nettype none
// ============================================================================
// Module  : rvfpm_mem_sched
// Brief   : FPU CORE-V-XIF memory scheduler: one in-order transaction at a
//           time, writeback of load data and a retire event per op.
//           Optional result watchdog: define RVFPM_MEM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rvfpm_mem_sched
  import rvfpm_mem_sched_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [X_ID_WIDTH-1:0]  op_id,
  input  logic                   op_we,
  input  logic [31:0]            op_addr,
  input  logic [2:0]             op_size,
  input  logic [4:0]             op_rd,
  input  logic [X_MEM_WIDTH-1:0] op_wdata,
  input  logic [1:0]             op_mode,
  input  logic                   commit_valid,
  input  logic [X_ID_WIDTH-1:0]  commit_id,
  input  logic                   commit_kill,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output x_mem_req_t             mem_req,
  input  logic                   mem_resp_exc,
  input  logic                   mem_result_valid,
  input  x_mem_result_t          mem_result,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic [FLEN-1:0]        wb_data,
  output logic                   ret_valid,
  output logic [X_ID_WIDTH-1:0]  ret_id,
  output logic                   ret_err
);

  mem_sched_state_t r_state;
  logic             r_err;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [FLEN-1:0]  r_wb_data;
  mem_q_entry_t     w_head;
  mem_q_entry_t     w_push_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_res_hit;
  logic [X_MEM_WIDTH-1:0] w_shifted;
  logic [FLEN-1:0]  w_load_data;
  x_mem_req_t       w_req;

  assign w_pop    = (r_state == ST_RETIRE);
  assign op_ready = !w_full || w_pop;

  always_comb begin
    w_push_entry           = '0;
    w_push_entry.id        = op_id;
    w_push_entry.we        = op_we;
    w_push_entry.addr      = op_addr;
    w_push_entry.size      = op_size;
    w_push_entry.rd        = op_rd;
    w_push_entry.wdata     = op_wdata;
    w_push_entry.mode      = op_mode;
  end

  rvfpm_mem_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (op_valid && op_ready),
    .push_entry   (w_push_entry),
    .pop          (w_pop),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .head         (w_head),
    .full         (w_full),
    .empty        (w_empty)
  );

  // Payload is a pure function of the head entry, so it is stable while stalled.
  always_comb begin
    w_req = '0;
    if (r_state == ST_REQ) begin
      w_req.id    = w_head.id;
      w_req.addr  = w_head.addr;
      w_req.mode  = w_head.mode;
      w_req.we    = w_head.we;
      w_req.size  = w_head.size;
      w_req.last  = 1'b1;
      w_req.wdata = w_head.wdata << {w_head.addr[1:0], 3'b000};
      case (w_head.size)
        MEM_SIZE_WORD: w_req.be = 4'hF;
        MEM_SIZE_HALF: w_req.be = 4'b0011 << w_head.addr[1:0];
        MEM_SIZE_BYTE: w_req.be = 4'b0001 << w_head.addr[1:0];
        default:       w_req.be = 4'h0;
      endcase
    end
  end

  assign mem_req   = w_req;
  assign mem_valid = (r_state == ST_REQ);

  assign w_res_hit = mem_result_valid && (mem_result.id == w_head.id);
  assign w_shifted = mem_result.rdata >> {w_head.addr[1:0], 3'b000};

  always_comb begin
    case (w_head.size)
      MEM_SIZE_BYTE: w_load_data = {24'h0, w_shifted[7:0]};
      MEM_SIZE_HALF: w_load_data = {16'h0, w_shifted[15:0]};
      default:       w_load_data = w_shifted;
    endcase
  end

`ifdef RVFPM_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_err      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
`ifdef RVFPM_MEM_TIMEOUT_EN
      r_to_cnt   <= '0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (w_head.killed) begin
              r_state <= ST_RETIRE;
              r_err   <= 1'b0;
            end else if (w_head.committed) begin
              if (mem_misaligned(w_head.size, w_head.addr[1:0])) begin
                r_state <= ST_RETIRE;
                r_err   <= 1'b1;
              end else begin
                r_state <= ST_REQ;
              end
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            if (mem_resp_exc) begin
              r_state <= ST_RETIRE;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_RESULT;
`ifdef RVFPM_MEM_TIMEOUT_EN
              r_to_cnt <= '0;
`endif
            end
          end
        end
        ST_RESULT: begin
          if (w_res_hit) begin
            r_state <= ST_RETIRE;
            r_err   <= mem_result.err;
            if (!w_head.we && !w_head.killed) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= w_head.rd;
              r_wb_data  <= w_load_data;
            end
          end
`ifdef RVFPM_MEM_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= ST_RETIRE;
            r_err   <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign ret_valid = (r_state == ST_RETIRE);
  assign ret_id    = w_head.id;
  assign ret_err   = r_err;

endmodule
`default_nettype wire

// File: doc/rvfpm_mem_sched.md
Name: rvfpm_mem_sched

Overview:
Scheduler for the FPU's CORE-V-XIF memory interface (FLW/FSW and narrower FP loads/stores).
- Buffers accepted load/store operations in order.
- Holds each one until the core commits or kills it.
- Drives one x_mem_req_t transaction at a time and matches x_mem_result_t to the outstanding op.
- Returns load data to the FP register file and a completion/retire event to the issue logic.

Parameters:
QUEUE_DEPTH, 4, pending load/store entries (power of two, >=2)
TIMEOUT_CYCLES, 1024, result watchdog limit (only with RVFPM_MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  new load/store from decode
op_ready  out  1  queue not full
op_id  in  X_ID_WIDTH  instruction id
op_we  in  1  1=store, 0=load
op_addr  in  32  virtual address
op_size  in  3  0=byte, 1=half, 2=word; others illegal
op_rd  in  5  FP destination register (loads)
op_wdata  in  X_MEM_WIDTH  store data from FP register
op_mode  in  2  privilege level
commit_valid  in  1  commit event
commit_id  in  X_ID_WIDTH  id being committed/killed
commit_kill  in  1  1=kill, 0=commit
mem_valid  out  1  memory request valid
mem_ready  in  1  core accepts request
mem_req  out  x_mem_req_t  request payload
mem_resp_exc  in  1  core flags exception on accepted request
mem_result_valid  in  1  result valid
mem_result  in  x_mem_result_t  result payload
wb_valid  out  1  load data write to FP RF
wb_rd  out  5  destination register
wb_data  out  FLEN  load data, NaN-boxing not applied (FLEN=32)
ret_valid  out  1  op finished (load, store, killed, or exception)
ret_id  out  X_ID_WIDTH  finished id
ret_err  out  1  bus error, misalignment, mem exception or timeout

Behaviour:
- Reset:
  - Queue empty, FSM IDLE.
  - mem_valid, wb_valid, ret_valid, ret_err = 0; mem_req = '0; op_ready = 1.
- Enqueue:
  - Occurs on op_valid & op_ready.
  - Entry stores all op fields plus committed=0, killed=0.
  - Full queue: op_ready=0.
  - Enqueue and dequeue in the same cycle when full is allowed: op_ready depends on dequeue that cycle.
- Commit/kill:
  - Matches every valid entry with equal id and sets committed or killed.
  - An unknown id is ignored.
  - A commit and enqueue of the same id in the same cycle applies to the new entry.
- FSM states: IDLE, REQ, RESULT, RETIRE.
  - IDLE, head valid & killed: go to RETIRE with ret_err=0, no memory access.
  - IDLE, head valid & committed & misaligned: go to RETIRE with ret_err=1. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size>2.
  - IDLE, head valid & committed & aligned: go to REQ.
  - REQ: mem_valid=1 with a stable payload until mem_ready.
    - Payload: id, addr, mode, we, size, attr=0, last=1, spec=0.
    - be: word 4'hF; half 4'b0011<<addr[1:0]; byte 4'b0001<<addr[1:0].
    - wdata: op_wdata shifted left by 8*addr[1:0].
    - On handshake with mem_resp_exc=1: go to RETIRE with ret_err=1, no result expected.
    - Otherwise go to RESULT.
  - RESULT: wait for mem_result_valid with mem_result.id == head id.
    - Results with other ids are ignored.
    - Load: wb_valid=1 for one cycle in the RESULT->RETIRE transition. wb_data = rdata>>8*addr[1:0], zero-extended to size (byte/half occupy the LSBs).
    - ret_err = mem_result.err.
    - A kill arriving during REQ/RESULT is recorded, but the transaction completes; wb_valid is suppressed if killed.
  - RETIRE: ret_valid=1 for one cycle, pop head, return to IDLE.
- Latency:
  - Committed aligned op reaches mem_valid 1 cycle after entering IDLE-head.
  - ret_valid arrives 1 cycle after the result.
- Reset mid-operation aborts everything immediately. Outstanding results after reset are ignored because the FSM is IDLE.

Optional Feature:
RVFPM_MEM_TIMEOUT_EN:
- Defined: a counter in RESULT increments each cycle. At TIMEOUT_CYCLES it forces RETIRE with ret_err=1 and wb_valid=0. The counter is cleared on RESULT entry.
- Undefined: no counter; RESULT waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- pa_rvfpm gains:
  - mem_sched_state_t enum (IDLE, REQ, RESULT, RETIRE).
  - mem_q_entry_t struct (id, we, addr, size, rd, wdata, mode, committed, killed).
  - MEM_SIZE_BYTE/HALF/WORD constants.
- The scheduler reuses the existing x_mem_req_t and x_mem_result_t.
- Sub-module rvfpm_mem_queue: circular FIFO with id-match commit/kill flag update, exposing head entry, full and empty.

Test Plan:
- Load word: op id=3, addr=0x100, size=2, commit id=3, mem_ready=1, result rdata=0x3F800000 -> mem_req be=0xF, wb_rd=op_rd, wb_data=0x3F800000, ret_id=3, ret_err=0.
- Store half: addr=0x102, wdata=0x0000ABCD, committed -> be=0b1100, mem_req.wdata=0xABCD0000, we=1, wb_valid never asserted, ret_valid once.
- Kill: enqueue ids 1,2; kill id 1, commit id 2 -> id 1 retires with no mem_valid; id 2 issues next.
- Backpressure: fill 4 entries -> op_ready=0; hold mem_ready=0 for 5 cycles -> mem_req stable; after first retire, op_ready=1.
- Misaligned word addr=0x101 -> no mem_valid, ret_err=1; mem_resp_exc=1 on a handshake -> ret_err=1, no wb.
- Reset asserted in RESULT -> all outputs 0 next edge; a late result is ignored. With RVFPM_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no result -> ret_err=1 after 8 cycles.
